// File: rtl/ili9341_pixel_fifo_if.sv
// picosoc iomem bus as seen by the ili9341 pixel FIFO.
// The CPU side is the master and the FIFO register block is the slave.
interface ili9341_pixel_fifo_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output valid,
        output wstrb,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  wstrb,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/ili9341_pixel_fifo.sv
// CPU-side pixel queue for the ili9341 driver: buffers RGB565 pixels and cursor resets
// from the iomem bus and replays them with a hold-until-accepted request handshake.
module ili9341_pixel_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned FRAME_PIXELS = 76800
) (
    input  logic                       clk_16MHz,
    input  logic                       resetn,
    ili9341_pixel_fifo_if.slave        iomem,
    output logic [15:0]                pix_data,
    output logic                       pix_clk,
    output logic                       reset_cursor,
    input  logic                       lcd_busy
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    localparam logic [PTR_W-1:0] LEVEL_FULL = PTR_W'(DEPTH);
    localparam logic [16:0]      FRAME_MAX  = 17'(FRAME_PIXELS);
    localparam logic [16:0]      CURSOR_ENTRY = 17'h1_0000;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CURSOR = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Entry layout: {is_cursor, pixel[15:0]}
    logic [16:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] level;
    logic             full;
    logic             empty;

    logic [1:0]       state_q;
    logic             req_is_cursor_q;
    logic [16:0]      pix_count_q;
    logic             auto_wrap_q;
    logic             ready_q;
    logic [31:0]      rdata_q;

    logic [1:0]       reg_sel;
    logic             is_write;
    logic             push_req;
    logic             push;
    logic [16:0]      push_entry;
    logic             wrap_due;
    logic             pop;
    logic [16:0]      head;
    logic [31:0]      status;
    logic [31:0]      read_data;
    logic             unused_bits;

    assign unused_bits = ^{iomem.addr[1:0], iomem.wdata[31:16]};

    assign iomem.ready = ready_q;
    assign iomem.rdata = rdata_q;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    assign reg_sel  = iomem.addr[3:2];
    assign is_write = |iomem.wstrb;

    assign push_req = iomem.valid && !ready_q && is_write &&
                      (reg_sel == REG_DATA || reg_sel == REG_CURSOR);
    assign push     = push_req && !full;

    assign push_entry = (reg_sel == REG_CURSOR) ? CURSOR_ENTRY : {1'b0, iomem.wdata[15:0]};

    assign head = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    // The frame-end cursor reset takes priority over whatever sits at the FIFO head.
    assign wrap_due = auto_wrap_q && (pix_count_q == FRAME_MAX);
    assign pop      = (state_q == ST_IDLE) && !lcd_busy && !wrap_due && !empty;

    always_comb begin
        status              = '0;
        status[31:15]       = pix_count_q;
        status[8 +: PTR_W]  = level;
        status[2]           = lcd_busy;
        status[1]           = full;
        status[0]           = empty;

        read_data = '0;
        case (reg_sel)
            REG_CTRL:   read_data = {31'd0, auto_wrap_q};
            REG_STATUS: read_data = status;
            default:    read_data = '0;
        endcase
    end

    always_ff @(posedge clk_16MHz) begin
        if (push) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_entry;
        end
    end

    // Bus side: pushes ack on the write edge, everything else one cycle after valid.
    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            auto_wrap_q <= 1'b0;
            wr_ptr_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            if (iomem.valid && !ready_q) begin
                if (push_req) begin
                    if (!full) begin
                        ready_q  <= 1'b1;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                end else begin
                    ready_q <= 1'b1;
                    if (is_write) begin
                        if (reg_sel == REG_CTRL) begin
                            auto_wrap_q <= iomem.wdata[0];
                        end
                    end else begin
                        rdata_q <= read_data;
                    end
                end
            end
        end
    end

    // Stream side: a request is held until the driver raises busy, then we wait for it to drop.
    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            pix_data        <= '0;
            pix_clk         <= 1'b0;
            reset_cursor    <= 1'b0;
            req_is_cursor_q <= 1'b0;
            pix_count_q     <= '0;
            rd_ptr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!lcd_busy) begin
                        if (wrap_due) begin
                            reset_cursor    <= 1'b1;
                            req_is_cursor_q <= 1'b1;
                            state_q         <= ST_REQ;
                        end else if (!empty) begin
                            rd_ptr_q        <= rd_ptr_q + 1'b1;
                            req_is_cursor_q <= head[16];
                            state_q         <= ST_REQ;
                            if (head[16]) begin
                                reset_cursor <= 1'b1;
                            end else begin
                                pix_data <= head[15:0];
                                pix_clk  <= 1'b1;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (lcd_busy) begin
                        pix_clk      <= 1'b0;
                        reset_cursor <= 1'b0;
                        state_q      <= ST_WAIT;
                        if (req_is_cursor_q) begin
                            pix_count_q <= '0;
                        end else if (pix_count_q != FRAME_MAX) begin
                            pix_count_q <= pix_count_q + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!lcd_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pops are only taken from IDLE, so the pop strobe is not otherwise referenced.
    logic unused_pop;
    assign unused_pop = pop;
endmodule

// File: tb/tb_ili9341_pixel_fifo.sv
// Scoreboard bench for ili9341_pixel_fifo: bus writes queue expected driver requests,
// a small driver model records accepted requests, and the two streams are compared in order.
module tb_ili9341_pixel_fifo;
    localparam int unsigned FRAME       = 4;
    localparam int unsigned BUSY_CYCLES = 3;

    logic        clk_16MHz = 1'b0;
    logic        resetn    = 1'b0;
    logic        lcd_busy;
    logic        pix_clk;
    logic        reset_cursor;
    logic [15:0] pix_data;

    ili9341_pixel_fifo_if bus ();

    ili9341_pixel_fifo #(
        .DEPTH_LOG2   (4),
        .FRAME_PIXELS (FRAME)
    ) dut (
        .clk_16MHz    (clk_16MHz),
        .resetn       (resetn),
        .iomem        (bus),
        .pix_data     (pix_data),
        .pix_clk      (pix_clk),
        .reset_cursor (reset_cursor),
        .lcd_busy     (lcd_busy)
    );

    always #31 clk_16MHz = ~clk_16MHz;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int unsigned model_count = 0;
    logic        model_wrap  = 1'b0;

    // Driver model: accepts a request after seeing it on two edges, then stays busy.
    logic        busy_stuck = 1'b0;
    logic        drv_stall  = 1'b0;
    logic        drv_busy   = 1'b0;
    logic        req_seen   = 1'b0;
    int          drv_cnt    = 0;
    logic [15:0] acc_data   = '0;
    logic        acc_cursor = 1'b0;
    int          proto_err  = 0;
    int          data_err   = 0;

    assign lcd_busy = drv_busy | busy_stuck;

    always @(posedge clk_16MHz) begin
        if (!resetn) begin
            drv_busy   <= 1'b0;
            req_seen   <= 1'b0;
            drv_cnt    <= 0;
            acc_data   <= '0;
            acc_cursor <= 1'b0;
        end else begin
            if (pix_clk && reset_cursor) proto_err <= proto_err + 1;
            if (drv_busy) begin
                if (!acc_cursor && pix_data !== acc_data) data_err <= data_err + 1;
                if (drv_cnt == 1) drv_busy <= 1'b0;
                drv_cnt <= drv_cnt - 1;
            end else if ((pix_clk || reset_cursor) && !busy_stuck) begin
                if (req_seen && !drv_stall) begin
                    drv_busy   <= 1'b1;
                    drv_cnt    <= BUSY_CYCLES;
                    req_seen   <= 1'b0;
                    acc_data   <= pix_data;
                    acc_cursor <= reset_cursor;
                    obs_q.push_back({reset_cursor, reset_cursor ? 16'h0 : pix_data});
                end else begin
                    req_seen <= 1'b1;
                end
            end else begin
                if (req_seen) proto_err <= proto_err + 1;
                req_seen <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [3:0] addr, input logic [3:0] strb,
                            input logic [31:0] data, output logic [31:0] rd);
        int n;
        @(posedge clk_16MHz); #1;
        bus.valid = 1'b1;
        bus.addr  = addr;
        bus.wstrb = strb;
        bus.wdata = data;
        n = 0;
        do begin
            @(posedge clk_16MHz); #1;
            n++;
        end while (!bus.ready && n < 200);
        if (!bus.ready) check_eq("bus_ack_timeout", 32'(bus.ready), 32'd1);
        rd        = bus.rdata;
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic read_reg(input logic [3:0] addr, output logic [31:0] rd);
        bus_xfer(addr, 4'h0, 32'hFFFF_FFFF, rd);
    endtask

    function automatic void model_pixel(input logic [15:0] p);
        exp_q.push_back({1'b0, p});
        if (model_count < FRAME) model_count++;
        if (model_wrap && model_count == FRAME) begin
            exp_q.push_back(17'h1_0000);
            model_count = 0;
        end
    endfunction

    task automatic push_pixel(input logic [15:0] p);
        logic [31:0] rd;
        model_pixel(p);
        bus_xfer(4'h0, 4'hF, {16'hDEAD, p}, rd);
    endtask

    task automatic push_cursor();
        logic [31:0] rd;
        exp_q.push_back(17'h1_0000);
        model_count = 0;
        bus_xfer(4'h4, 4'h1, 32'h0, rd);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || obs_q.size() != 0) && n < 2000) begin
            @(negedge clk_16MHz);
            n++;
            while (obs_q.size() != 0 && exp_q.size() != 0) begin
                logic [16:0] o;
                logic [16:0] e;
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                check_eq("stream", {15'd0, o}, {15'd0, e});
            end
            if (obs_q.size() != 0) begin
                check_eq("stream_extra", 32'(obs_q.size()), 32'd0);
                obs_q.delete();
            end
        end
        if (n >= 2000) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (12) @(negedge clk_16MHz);
        check_eq("stream_tail", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        check_eq("req_held", 32'(proto_err), 32'd0);
        check_eq("data_held", 32'(data_err), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_16MHz); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk_16MHz);
        #1;
        resetn      = 1'b1;
        model_count = 0;
        model_wrap  = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        repeat (60000) @(posedge clk_16MHz);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          n;
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        bus.addr  = 4'h0;
        bus.wdata = 32'h0;
        repeat (3) @(posedge clk_16MHz);
        #1;
        resetn = 1'b1;

        // Reset state
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        check_eq("rst_pix_data", 32'(pix_data), 32'd0);
        check_eq("rst_pix_clk", 32'(pix_clk), 32'd0);
        check_eq("rst_reset_cursor", 32'(reset_cursor), 32'd0);
        read_reg(4'hC, rd);
        check_eq("rst_status", rd, 32'h1);
        @(posedge clk_16MHz); #1;
        check_eq("ready_pulse", 32'(bus.ready), 32'd0);
        read_reg(4'h0, rd);
        check_eq("read_data_reg", rd, 32'd0);
        read_reg(4'h4, rd);
        check_eq("read_cursor_reg", rd, 32'd0);
        read_reg(4'h8, rd);
        check_eq("rst_ctrl", rd, 32'd0);

        // 1) Three primaries through the driver model
        push_pixel(16'hF800);
        push_pixel(16'h07E0);
        push_pixel(16'h001F);
        drain();
        read_reg(4'hC, rd);
        check_eq("t1_pix_count", 32'(rd[31:15]), 32'(model_count));
        check_eq("t1_level", 32'(rd[12:0]), 32'h1);

        // 2) Fill with the driver stuck busy, then stall the 17th write
        busy_stuck = 1'b1;
        for (int i = 0; i < 16; i++) push_pixel(16'h1100 + 16'(i));
        read_reg(4'hC, rd);
        check_eq("t2_level", 32'(rd[12:8]), 32'd16);
        check_eq("t2_flags", 32'(rd[2:0]), 32'b110);
        model_pixel(16'h1117);
        @(posedge clk_16MHz); #1;
        bus.valid = 1'b1;
        bus.addr  = 4'h0;
        bus.wstrb = 4'hF;
        bus.wdata = 32'h0000_1117;
        n = 0;
        repeat (6) begin
            @(posedge clk_16MHz); #1;
            if (bus.ready) n++;
        end
        check_eq("t2_stall_ready", 32'(n), 32'd0);
        busy_stuck = 1'b0;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk_16MHz); #1;
            n++;
        end
        check_eq("t2_stall_ack", 32'(bus.ready), 32'd1);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        drain();

        // 3) Pixel, cursor, pixel
        do_reset();
        push_pixel(16'hABCD);
        push_cursor();
        push_pixel(16'h1234);
        drain();
        read_reg(4'hC, rd);
        check_eq("t3_pix_count", 32'(rd[31:15]), 32'(model_count));

        // 4) Auto-wrap after FRAME pixels
        do_reset();
        bus_xfer(4'h8, 4'hF, 32'h1, rd);
        model_wrap = 1'b1;
        read_reg(4'h8, rd);
        check_eq("t4_ctrl", rd, 32'd1);
        for (int i = 0; i < 6; i++) push_pixel(16'h4000 + 16'(i));
        drain();
        read_reg(4'hC, rd);
        check_eq("t4_pix_count", 32'(rd[31:15]), 32'(model_count));
        bus_xfer(4'h8, 4'hF, 32'h0, rd);
        model_wrap = 1'b0;

        // 4b) Counter saturates at FRAME without auto-wrap
        do_reset();
        for (int i = 0; i < 6; i++) push_pixel(16'h5000 + 16'(i));
        drain();
        read_reg(4'hC, rd);
        check_eq("t4b_saturate", 32'(rd[31:15]), 32'(model_count));

        // 5) Reset while a request is pending
        do_reset();
        drv_stall = 1'b1;
        bus_xfer(4'h0, 4'hF, 32'h5555, rd);
        bus_xfer(4'h0, 4'hF, 32'h6666, rd);
        n = 0;
        while (!pix_clk && n < 50) begin
            @(posedge clk_16MHz); #1;
            n++;
        end
        check_eq("t5_req_up", 32'(pix_clk), 32'd1);
        repeat (3) @(posedge clk_16MHz);
        #1;
        resetn = 1'b0;
        @(posedge clk_16MHz); #1;
        check_eq("t5_pix_clk", 32'(pix_clk), 32'd0);
        check_eq("t5_reset_cursor", 32'(reset_cursor), 32'd0);
        resetn    = 1'b1;
        drv_stall = 1'b0;
        read_reg(4'hC, rd);
        check_eq("t5_status", rd, 32'h1);
        drain();

        // 6) Push and pop on the same edge at level 5
        do_reset();
        busy_stuck = 1'b1;
        for (int i = 0; i < 5; i++) push_pixel(16'h6000 + 16'(i));
        read_reg(4'hC, rd);
        check_eq("t6_level_before", 32'(rd[12:8]), 32'd5);
        model_pixel(16'h6005);
        @(posedge clk_16MHz); #1;
        bus.valid  = 1'b1;
        bus.addr   = 4'h0;
        bus.wstrb  = 4'hF;
        bus.wdata  = 32'h0000_6005;
        busy_stuck = 1'b0;
        n = 0;
        do begin
            @(posedge clk_16MHz); #1;
            n++;
        end while (!bus.ready && n < 100);
        check_eq("t6_ack", 32'(bus.ready), 32'd1);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        read_reg(4'hC, rd);
        check_eq("t6_level_after", 32'(rd[12:8]), 32'd5);
        drain();
        read_reg(4'hC, rd);
        check_eq("t6_empty", 32'(rd[12:0]), 32'h1);
        check_eq("t6_pix_count", 32'(rd[31:15]), 32'(model_count));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
